// File: rtl/tlb_op_seq_if.sv
// Handshake and TLB/CSR port bundle between WB, the TLB arrays and the
// maintenance-op sequencer. The sequencer attaches through the slave modport.
interface tlb_op_seq_if #(
  parameter int IDX_W = 4
);
  // WB request
  logic              req_valid;
  logic [2:0]        req_op;
  logic [4:0]        req_inv_op;
  logic [9:0]        req_inv_asid;
  logic [18:0]       req_inv_vppn;
  // CSR sources
  logic [31:0]       csr_tlbidx;
  logic [18:0]       csr_tlbehi_vppn;
  logic [9:0]        csr_asid;
  // TLB search port
  logic              s_found;
  logic [IDX_W-1:0]  s_index;
  logic [18:0]       s_vppn;
  logic [9:0]        s_asid;
  // TLB read port
  logic [IDX_W-1:0]  r_index;
  logic              r_e;
  logic              r_g;
  logic [9:0]        r_asid;
  logic [18:0]       r_vppn;
  // TLB write port
  logic              w_en;
  logic              w_clr;
  logic [IDX_W-1:0]  w_index;
  // Status and CSR update strobes
  logic              busy;
  logic              done;
  logic              srch_we;
  logic              srch_hit;
  logic [IDX_W-1:0]  srch_idx;
  logic              rd_we;

  modport master (
    output req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
           csr_tlbidx, csr_tlbehi_vppn, csr_asid,
           s_found, s_index, r_e, r_g, r_asid, r_vppn,
    input  s_vppn, s_asid, r_index, w_en, w_clr, w_index,
           busy, done, srch_we, srch_hit, srch_idx, rd_we
  );

  modport slave (
    input  req_valid, req_op, req_inv_op, req_inv_asid, req_inv_vppn,
           csr_tlbidx, csr_tlbehi_vppn, csr_asid,
           s_found, s_index, r_e, r_g, r_asid, r_vppn,
    output s_vppn, s_asid, r_index, w_en, w_clr, w_index,
           busy, done, srch_we, srch_hit, srch_idx, rd_we
  );
endinterface

// File: rtl/tlb_op_seq.sv
// TLB maintenance-op sequencer: runs TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// issued from WB, drives the TLB ports, pulses CSR update strobes and
// holds WB off with busy. INVTLB walks every entry, one per cycle.
module tlb_op_seq #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input logic         clk,
  input logic         rst,
  tlb_op_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_DONE
  } state_e;

  localparam logic [2:0]       OP_SRCH  = 3'd0;
  localparam logic [2:0]       OP_RD    = 3'd1;
  localparam logic [2:0]       OP_WR    = 3'd2;
  localparam logic [2:0]       OP_FILL  = 3'd3;
  localparam logic [2:0]       OP_INV   = 3'd4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [4:0]       inv_op_q;
  logic [9:0]       inv_asid_q;
  logic [18:0]      inv_vppn_q;
  logic [IDX_W-1:0] fill_ctr_q;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             rule_hit;
  logic             match;
  logic             unused_tlbidx_hi;

  // Only the index field of TLBIDX is consumed here.
  assign unused_tlbidx_hi = ^bus.csr_tlbidx[31:IDX_W];

  // INVTLB match rule for the entry currently on the read port.
  always_comb begin
    rule_hit = 1'b0;
    case (inv_op_q)
      5'd0, 5'd1: rule_hit = 1'b1;
      5'd2:       rule_hit = bus.r_g;
      5'd3:       rule_hit = !bus.r_g;
      5'd4:       rule_hit = !bus.r_g && (bus.r_asid == inv_asid_q);
      5'd5:       rule_hit = !bus.r_g && (bus.r_asid == inv_asid_q)
                             && (bus.r_vppn == inv_vppn_q);
      5'd6:       rule_hit = (bus.r_g || (bus.r_asid == inv_asid_q))
                             && (bus.r_vppn == inv_vppn_q);
      default:    rule_hit = 1'b0;
    endcase
    match = bus.r_e && rule_hit;
  end

  // Next state and port drive; strobes are masked while rst is high so a
  // reset landing mid-op issues no further TLB or CSR writes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned; that is what keeps this block free of latches.
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.s_vppn   = '0;
    bus.s_asid   = '0;
    bus.r_index  = '0;
    bus.w_en     = 1'b0;
    bus.w_clr    = 1'b0;
    bus.w_index  = '0;
    bus.srch_we  = 1'b0;
    bus.srch_hit = 1'b0;
    bus.srch_idx = '0;
    bus.rd_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_SRCH:         state_d = S_SRCH;
            OP_RD:           state_d = S_RD;
            OP_WR, OP_FILL:  state_d = S_WR;
            OP_INV:          state_d = S_INV;
            default:         state_d = S_DONE;
          endcase
        end
      end
      S_SRCH: begin
        bus.s_vppn   = bus.csr_tlbehi_vppn;
        bus.s_asid   = bus.csr_asid;
        bus.srch_we  = !rst;
        bus.srch_hit = bus.s_found;
        bus.srch_idx = bus.s_found ? bus.s_index : '0;
        state_d      = S_DONE;
      end
      S_RD: begin
        bus.r_index = bus.csr_tlbidx[IDX_W-1:0];
        bus.rd_we   = !rst;
        state_d     = S_DONE;
      end
      S_WR: begin
        bus.w_en    = !rst;
        bus.w_index = (op_q == OP_FILL) ? fill_ctr_q : bus.csr_tlbidx[IDX_W-1:0];
        state_d     = S_DONE;
      end
      S_INV: begin
        bus.r_index = scan_idx_q;
        bus.w_index = scan_idx_q;
        bus.w_en    = match && !rst;
        bus.w_clr   = match && !rst;
        if (scan_idx_q == LAST_IDX) begin
          scan_idx_d = '0;
          state_d    = S_DONE;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, scan pointer, free-running fill counter and latched operands.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      scan_idx_q <= '0;
      fill_ctr_q <= '0;
      op_q       <= '0;
      inv_op_q   <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      fill_ctr_q <= fill_ctr_q + IDX_W'(1);
      if ((state_q == S_IDLE) && bus.req_valid) begin
        op_q       <= bus.req_op;
        inv_op_q   <= bus.req_inv_op;
        inv_asid_q <= bus.req_inv_asid;
        inv_vppn_q <= bus.req_inv_vppn;
      end
    end
  end

endmodule

// File: tb/tb_tlb_op_seq.sv
// Self-checking bench for tlb_op_seq: a small TLB array model answers the
// read port and absorbs writes; directed steps then randomized ops are
// compared with expectations derived from the op rules.
module tb_tlb_op_seq;
  localparam int TLBNUM = 16;
  localparam int IDX_W  = 4;

  logic clk;
  logic rst;
  tlb_op_seq_if #(.IDX_W(IDX_W)) bus ();

  tlb_op_seq #(.TLBNUM(TLBNUM), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TLB contents model
  logic        tlb_e    [TLBNUM];
  logic        tlb_g    [TLBNUM];
  logic [9:0]  tlb_asid [TLBNUM];
  logic [18:0] tlb_vppn [TLBNUM];

  assign bus.r_e    = tlb_e[bus.r_index];
  assign bus.r_g    = tlb_g[bus.r_index];
  assign bus.r_asid = tlb_asid[bus.r_index];
  assign bus.r_vppn = tlb_vppn[bus.r_index];

  // Writes observed mid-cycle, as {clr, index}
  logic [IDX_W:0] wlog[$];
  logic [IDX_W:0] exp_w[$];

  always @(negedge clk) begin
    if (bus.w_en) begin
      wlog.push_back({bus.w_clr, bus.w_index});
      if (bus.w_clr) begin
        tlb_e[bus.w_index] = 1'b0;
      end else begin
        tlb_e[bus.w_index]    = 1'b1;
        tlb_g[bus.w_index]    = 1'b0;
        tlb_asid[bus.w_index] = bus.csr_asid;
        tlb_vppn[bus.w_index] = bus.csr_tlbehi_vppn;
      end
    end
  end

  // Clock edges since reset; the fill counter must equal this mod TLBNUM.
  int edges;
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-op observations
  int          lat, n_srch, n_rd, n_busy_lo, srch_cyc, exp_fill;
  logic        got_hit;
  logic [3:0]  got_sidx, got_ridx;
  logic [18:0] got_svppn;
  logic [9:0]  got_sasid;

  task automatic run_op(input logic [2:0] op, input logic [4:0] iop,
                        input logic [9:0] iasid, input logic [18:0] ivppn);
    wlog.delete();
    n_srch = 0; n_rd = 0; n_busy_lo = 0; srch_cyc = 0;
    got_hit = 1'b0; got_sidx = '0; got_ridx = '0; got_svppn = '0; got_sasid = '0;
    bus.req_op       = op;
    bus.req_inv_op   = iop;
    bus.req_inv_asid = iasid;
    bus.req_inv_vppn = ivppn;
    bus.req_valid    = 1'b1;
    tick();
    lat = 1;
    forever begin
      if (lat == 1) exp_fill = edges % TLBNUM;
      if (!bus.busy) n_busy_lo++;
      if (bus.srch_we) begin
        n_srch++; srch_cyc = lat;
        got_hit = bus.srch_hit; got_sidx = bus.srch_idx;
        got_svppn = bus.s_vppn; got_sasid = bus.s_asid;
      end
      if (bus.rd_we) begin
        n_rd++; got_ridx = bus.r_index;
      end
      if (bus.done || lat >= 40) break;
      tick();
      lat++;
    end
    bus.req_valid = 1'b0;
    tick();
  endtask

  function automatic bit inv_rule(input int iop, input bit e, input bit g,
                                  input int asid, input int vppn,
                                  input int qasid, input int qvppn);
    bit a = (asid == qasid);
    bit v = (vppn == qvppn);
    if (!e) return 1'b0;
    case (iop)
      0, 1:    return 1'b1;
      2:       return g;
      3:       return !g;
      4:       return !g && a;
      5:       return !g && a && v;
      6:       return (g || a) && v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_tlb();
    for (int i = 0; i < TLBNUM; i++) begin
      tlb_e[i] = 1'b0; tlb_g[i] = 1'b0; tlb_asid[i] = '0; tlb_vppn[i] = '0;
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [4:0]  iop;
    logic [9:0]  iasid;
    logic [18:0] ivppn;
    int          exp_lat, exp_ns, exp_nr, first_fill;

    clear_tlb();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_inv_op = '0;
    bus.req_inv_asid = '0; bus.req_inv_vppn = '0;
    bus.csr_tlbidx = '0; bus.csr_tlbehi_vppn = '0; bus.csr_asid = '0;
    bus.s_found = 1'b0; bus.s_index = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_w_en", bus.w_en, 0);
      check("idle_srch_we", bus.srch_we, 0);
      check("idle_rd_we", bus.rd_we, 0);
    end

    // SRCH hit
    bus.csr_tlbehi_vppn = 19'h1234; bus.csr_asid = 10'd5;
    bus.s_found = 1'b1; bus.s_index = 4'd7;
    run_op(3'd0, '0, '0, '0);
    check("srch_lat", lat, 2);
    check("srch_cnt", n_srch, 1);
    check("srch_cyc", srch_cyc, 1);
    check("srch_hit", got_hit, 1);
    check("srch_idx", got_sidx, 7);
    check("srch_key_vppn", got_svppn, 32'h1234);
    check("srch_key_asid", got_sasid, 5);
    check("srch_idle_after", bus.busy, 0);

    // SRCH miss
    bus.s_found = 1'b0; bus.s_index = 4'd11;
    run_op(3'd0, '0, '0, '0);
    check("miss_cnt", n_srch, 1);
    check("miss_hit", got_hit, 0);
    check("miss_idx", got_sidx, 0);

    // RD and WR
    bus.csr_tlbidx = 32'hA5A5_0003;
    run_op(3'd1, '0, '0, '0);
    check("rd_cnt", n_rd, 1);
    check("rd_index", got_ridx, 3);
    check("rd_no_write", wlog.size(), 0);
    bus.csr_tlbidx = 32'h0000_0009;
    run_op(3'd2, '0, '0, '0);
    check("wr_cnt", wlog.size(), 1);
    if (wlog.size() > 0) check("wr_entry", wlog[0], {1'b0, 4'd9});

    // FILL at a known counter value, then back to back
    while (edges % TLBNUM != 13) tick();
    run_op(3'd3, '0, '0, '0);
    check("fill_cnt", wlog.size(), 1);
    first_fill = (wlog.size() > 0) ? int'(wlog[0]) : -1;
    check("fill_14", first_fill, {27'd0, 1'b0, 4'd14});
    run_op(3'd3, '0, '0, '0);
    check("fill2_cnt", wlog.size(), 1);
    if (wlog.size() > 0) check("fill2_distinct", int'(wlog[0]) != first_fill, 1);

    // INVTLB op5
    clear_tlb();
    tlb_e[4] = 1; tlb_g[4] = 0; tlb_asid[4] = 10'd2; tlb_vppn[4] = 19'h55;
    tlb_e[9] = 1; tlb_g[9] = 1; tlb_asid[9] = 10'd2; tlb_vppn[9] = 19'h55;
    tlb_e[1] = 1; tlb_g[1] = 0; tlb_asid[1] = 10'd3; tlb_vppn[1] = 19'h55;
    run_op(3'd4, 5'd5, 10'd2, 19'h55);
    check("inv5_lat", lat, 17);
    check("inv5_cnt", wlog.size(), 1);
    if (wlog.size() > 0) check("inv5_entry", wlog[0], {1'b1, 4'd4});
    check("inv5_e4", tlb_e[4], 0);
    check("inv5_e9", tlb_e[9], 1);
    check("inv5_e1", tlb_e[1], 1);

    // Reset during an INVTLB scan at index 6
    for (int i = 0; i < TLBNUM; i++) tlb_e[i] = 1'b1;
    wlog.delete();
    bus.req_op = 3'd4; bus.req_inv_op = 5'd0; bus.req_valid = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      if (bus.busy && bus.r_index == 4'd6) break;
      tick();
    end
    check("rstinv_reached6", bus.r_index, 6);
    rst = 1'b1; bus.req_valid = 1'b0;
    tick();
    check("rstinv_idle", bus.busy, 0);
    check("rstinv_writes", wlog.size(), 6);
    check("rstinv_e5", tlb_e[5], 0);
    check("rstinv_e6", tlb_e[6], 1);
    check("rstinv_e15", tlb_e[15], 1);
    rst = 1'b0;
    tick();

    // Randomized ops against the rule model
    for (int n = 0; n < 60; n++) begin
      op    = 3'($urandom_range(0, 7));
      iop   = 5'($urandom_range(0, 7));
      iasid = 10'($urandom_range(0, 3));
      ivppn = 19'($urandom_range(0, 3));
      for (int i = 0; i < TLBNUM; i++) begin
        tlb_e[i] = 1'($urandom); tlb_g[i] = 1'($urandom);
        tlb_asid[i] = 10'($urandom_range(0, 3)); tlb_vppn[i] = 19'($urandom_range(0, 3));
      end
      bus.s_found = 1'($urandom); bus.s_index = 4'($urandom);
      bus.csr_tlbidx = $urandom;
      bus.csr_asid = 10'($urandom); bus.csr_tlbehi_vppn = 19'($urandom);

      exp_w.delete();
      exp_lat = 2; exp_ns = 0; exp_nr = 0;
      case (op)
        3'd0: exp_ns = 1;
        3'd1: exp_nr = 1;
        3'd2: exp_w.push_back({1'b0, bus.csr_tlbidx[3:0]});
        3'd3: ;
        3'd4: begin
          exp_lat = TLBNUM + 1;
          for (int i = 0; i < TLBNUM; i++)
            if (inv_rule(int'(iop), tlb_e[i], tlb_g[i], int'(tlb_asid[i]), int'(tlb_vppn[i]),
                         int'(iasid), int'(ivppn)))
              exp_w.push_back({1'b1, 4'(i)});
        end
        default: exp_lat = 1;
      endcase

      run_op(op, iop, iasid, ivppn);
      if (op == 3'd3) exp_w.push_back({1'b0, 4'(exp_fill)});

      check($sformatf("rnd%0d_op%0d_lat", n, op), lat, exp_lat);
      check($sformatf("rnd%0d_busy", n), n_busy_lo, 0);
      check($sformatf("rnd%0d_srch_cnt", n), n_srch, exp_ns);
      check($sformatf("rnd%0d_rd_cnt", n), n_rd, exp_nr);
      check($sformatf("rnd%0d_wcnt", n), wlog.size(), exp_w.size());
      if (wlog.size() == exp_w.size())
        for (int i = 0; i < exp_w.size(); i++)
          check($sformatf("rnd%0d_w%0d", n, i), wlog[i], exp_w[i]);
      if (op == 3'd0) begin
        check($sformatf("rnd%0d_hit", n), got_hit, bus.s_found);
        check($sformatf("rnd%0d_sidx", n), got_sidx, bus.s_found ? bus.s_index : 4'd0);
      end
      if (op == 3'd1) check($sformatf("rnd%0d_ridx", n), got_ridx, bus.csr_tlbidx[3:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
